muldiv_seq: RTL

- Multi-cycle sequencer for the RV32M extension, sitting in the EX stage beside the single-cycle ALU.
- Accepts a MUL/DIV/REM request when the EX-stage decode sees an R-type op with funct7 = 0000001.
- Stalls the pipeline while iterating, then presents a 32-bit result for one cycle so EX can advance.
- Runs shift-add multiply and restoring divide on operand magnitudes, with a final sign-fix cycle.

---
 rtl/muldiv_seq_pkg.sv | 32 +++
 rtl/muldiv_div_step.sv | 29 ++
 rtl/muldiv_seq.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_pkg.sv
// Shared constants, state encoding and operand-signedness helpers for the RV32M sequencer.
package muldiv_seq_pkg;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } muldiv_state_e;

  function automatic logic a_is_signed(input logic [2:0] f3);
    return (f3 == FUNCT3_MULH) || (f3 == FUNCT3_MULHSU) ||
           (f3 == FUNCT3_DIV)  || (f3 == FUNCT3_REM);
  endfunction

  function automatic logic b_is_signed(input logic [2:0] f3);
    return (f3 == FUNCT3_MULH) || (f3 == FUNCT3_DIV) || (f3 == FUNCT3_REM);
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-divide step: shift in the next dividend bit, trial subtract, emit a quotient bit.
module muldiv_div_step
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN:0] shifted_s;
  logic [XLEN:0] diff_s;

  // Shifted remainder is below twice the divisor, so the diff MSB is a clean borrow flag.
  always_comb begin
    shifted_s = {rem_in, quo_in[XLEN-1]};
    diff_s    = shifted_s - {1'b0, divisor};
    if (diff_s[XLEN]) begin
      rem_out = shifted_s[XLEN-1:0];
    end else begin
      rem_out = diff_s[XLEN-1:0];
    end
    quo_out = {quo_in[XLEN-2:0], ~diff_s[XLEN]};
  end

endmodule

// File: rtl/muldiv_seq.sv
// RV32M multi-cycle MUL/DIV/REM sequencer for the EX stage.
// Define MULDIV_FAST_MUL_EN for a registered 33x33 multiplier (2-cycle multiply).
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic n);
    return n ? (~v + XLEN'(1)) : v;
  endfunction

  muldiv_state_e   state_q;
  logic [2:0]      f3_q;
  logic            a_neg_q, b_neg_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0] b_q, rem_q, quo_q, result_q;
  logic            busy_q, done_q;

  logic            a_neg_s, b_neg_s, div_zero_s, div_ovf_s, last_step_s;
  logic [XLEN-1:0] a_mag_s, b_mag_s, special_s;
  logic [XLEN-1:0] rem_step_s, quo_step_s, fix_res_s;

  assign a_neg_s     = a_is_signed(funct3) & op_a[XLEN-1];
  assign b_neg_s     = b_is_signed(funct3) & op_b[XLEN-1];
  assign a_mag_s     = cond_neg(op_a, a_neg_s);
  assign b_mag_s     = cond_neg(op_b, b_neg_s);
  assign div_zero_s  = (op_b == '0);
  assign div_ovf_s   = b_is_signed(funct3) && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
  assign special_s   = div_zero_s ? (funct3[1] ? op_a : '1) : (funct3[1] ? '0 : op_a);
  assign last_step_s = (cnt_q == CNT_W'(XLEN-1));

  muldiv_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (b_q),
    .rem_out (rem_step_s),
    .quo_out (quo_step_s)
  );

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     fa_q, fb_q;
  logic signed [2*XLEN+1:0] fprod_s;
  assign fprod_s = (2*XLEN+2)'(fa_q) * (2*XLEN+2)'(fb_q);
`else
  logic [XLEN-1:0]   a_q;
  logic [2*XLEN-1:0] prod_q, prod_d, prod_fix_s;
  logic [XLEN:0]     sum_s;
  assign sum_s      = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, a_q} : {(XLEN+1){1'b0}});
  assign prod_d     = {sum_s, prod_q[XLEN-1:1]};
  assign prod_fix_s = (a_neg_q ^ b_neg_q) ? (~prod_q + (2*XLEN)'(1)) : prod_q;
`endif

  // Result selection for the sign-fix cycle.
  always_comb begin
    fix_res_s = '0;
    case (f3_q)
      FUNCT3_DIV, FUNCT3_DIVU: fix_res_s = cond_neg(quo_q, a_neg_q ^ b_neg_q);
      FUNCT3_REM, FUNCT3_REMU: fix_res_s = cond_neg(rem_q, a_neg_q);
`ifdef MULDIV_FAST_MUL_EN
      default:                 fix_res_s = '0;
`else
      FUNCT3_MUL:              fix_res_s = prod_fix_s[XLEN-1:0];
      default:                 fix_res_s = prod_fix_s[2*XLEN-1:XLEN];
`endif
    endcase
  end

  // Sequencer FSM with registered busy/done/result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      f3_q     <= 3'b000;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      cnt_q    <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef MULDIV_FAST_MUL_EN
      fa_q     <= '0;
      fb_q     <= '0;
`else
      a_q      <= '0;
      prod_q   <= '0;
`endif
    end else if (flush) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            f3_q    <= funct3;
            a_neg_q <= a_neg_s;
            b_neg_q <= b_neg_s;
            cnt_q   <= '0;
            b_q     <= b_mag_s;
            busy_q  <= 1'b1;
            if (funct3[2]) begin
              rem_q <= '0;
              quo_q <= a_mag_s;
              if (div_zero_s || div_ovf_s) begin
                result_q <= special_s;
                done_q   <= 1'b1;
                state_q  <= ST_DONE;
              end else begin
                state_q <= ST_DIV;
              end
            end else begin
`ifdef MULDIV_FAST_MUL_EN
              fa_q <= {a_is_signed(funct3) & op_a[XLEN-1], op_a};
              fb_q <= {b_is_signed(funct3) & op_b[XLEN-1], op_b};
`else
              a_q    <= a_mag_s;
              prod_q <= {{XLEN{1'b0}}, b_mag_s};
`endif
              state_q <= ST_MUL;
            end
          end
        end
        ST_MUL: begin
`ifdef MULDIV_FAST_MUL_EN
          result_q <= (f3_q == FUNCT3_MUL) ? fprod_s[XLEN-1:0] : fprod_s[2*XLEN-1:XLEN];
          done_q   <= 1'b1;
          state_q  <= ST_DONE;
`else
          prod_q <= prod_d;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (last_step_s) state_q <= ST_FIX;
`endif
        end
        ST_DIV: begin
          rem_q <= rem_step_s;
          quo_q <= quo_step_s;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_step_s) state_q <= ST_FIX;
        end
        ST_FIX: begin
          result_q <= fix_res_s;
          done_q   <= 1'b1;
          state_q  <= ST_DONE;
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign stall  = ((state_q == ST_IDLE) & start & ~flush) |
                  (state_q == ST_MUL) | (state_q == ST_DIV) | (state_q == ST_FIX);
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
